fmul_seq: RTL and testbench

- Iterative IEEE-754-style floating-point multiplier, the multiplicative counterpart to the team's combinational divider.
- Uses a shift-add mantissa datapath, one partial product per clock.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Same special-case, flush-to-zero and truncation policy as the divider.

---
 rtl/fmul_seq_if.sv | 23 ++
 rtl/fmul_seq.sv | 167 ++++++++++++++++
 tb/tb_fmul_seq.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fmul_seq_if.sv
// Operand/result handshake bundle for the sequential floating-point multiplier.
// The producer and consumer sit on the master side; the multiplier is the slave.
interface fmul_seq_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/fmul_seq.sv
// Iterative floating-point multiplier: one shift-add partial product per clock,
// flush-to-zero on denormals, truncating normalisation, valid/ready on both sides.
module fmul_seq #(
  parameter int N = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  fmul_seq_if.slave   bus
);
  localparam int EXP_LEN = (N == 64) ? 11 : 8;
  localparam int MAN     = N - EXP_LEN - 2;
  localparam int M       = MAN + 2;
  localparam int CW      = $clog2(M);
  localparam int EW      = EXP_LEN + 2;
  localparam logic signed [EW-1:0] BIAS   = EW'((1 << (EXP_LEN - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX   = EW'((1 << EXP_LEN) - 1);
  localparam logic signed [EW-1:0] EZERO  = EW'(0);
  localparam logic        [CW-1:0] LAST   = CW'(M - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] CLS_NORMAL = 2'd0;
  localparam logic [1:0] CLS_NAN    = 2'd1;
  localparam logic [1:0] CLS_INF    = 2'd2;
  localparam logic [1:0] CLS_ZERO   = 2'd3;

  // Priority order matters: NaN inputs, then Inf*0, then Inf, then zero/denormal.
  function automatic logic [1:0] classify(
    input logic [EXP_LEN-1:0] ea, input logic [MAN:0] ma,
    input logic [EXP_LEN-1:0] eb, input logic [MAN:0] mb
  );
    logic a_inf, b_inf, a_zero, b_zero;
    a_inf  = (&ea) && !(|ma);
    b_inf  = (&eb) && !(|mb);
    a_zero = (ea == {EXP_LEN{1'b0}});
    b_zero = (eb == {EXP_LEN{1'b0}});
    if (((&ea) && (|ma)) || ((&eb) && (|mb)))             classify = CLS_NAN;
    else if ((a_inf && b_zero) || (b_inf && a_zero))       classify = CLS_NAN;
    else if (a_inf || b_inf)                               classify = CLS_INF;
    else if (a_zero || b_zero)                             classify = CLS_ZERO;
    else                                                   classify = CLS_NORMAL;
  endfunction

  function automatic logic [N-1:0] encode_special(input logic sign, input logic [1:0] cls);
    case (cls)
      CLS_NAN:  encode_special = {sign, {EXP_LEN{1'b1}}, {(MAN+1){1'b1}}};
      CLS_INF:  encode_special = {sign, {EXP_LEN{1'b1}}, {(MAN+1){1'b0}}};
      default:  encode_special = {sign, {(N-1){1'b0}}};
    endcase
  endfunction

  state_t                 state_q, state_d;
  logic [N-1:0]           a_q, a_d, b_q, b_d;
  logic [CW-1:0]          count_q, count_d;
  logic [2*M-1:0]         acc_q, acc_d;
  logic [N-1:0]           out_q, out_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;

  logic                   accept_s;
  logic                   sign_in_s, sign_s;
  logic [1:0]             cls_s;
  logic [M-1:0]           sa_s, sb_s;
  logic signed [EW-1:0]   e_base_s, e_s;
  logic [MAN:0]           mant_s;

  assign accept_s  = in_ready_q && bus.in_valid;
  assign sign_in_s = bus.a[N-1] ^ bus.b[N-1];
  assign sign_s    = a_q[N-1] ^ b_q[N-1];
  assign cls_s     = classify(bus.a[N-2:MAN+1], bus.a[MAN:0], bus.b[N-2:MAN+1], bus.b[MAN:0]);
  assign sa_s      = {1'b1, a_q[MAN:0]};
  assign sb_s      = {1'b1, b_q[MAN:0]};
  // acc top bit set means the product is in [2,4): bump exponent, take one bit higher.
  assign e_base_s  = $signed({2'b00, a_q[N-2:MAN+1]}) + $signed({2'b00, b_q[N-2:MAN+1]}) - BIAS;
  assign e_s       = e_base_s + $signed({{(EW-1){1'b0}}, acc_q[2*M-1]});
  assign mant_s    = acc_q[2*M-1] ? acc_q[2*M-2:M] : acc_q[2*M-3:M-1];

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      count_q     <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) state_d = (cls_s != CLS_NORMAL) ? DONE : MUL;
        else          state_d = IDLE;
      end
      MUL: begin
        if (count_q == LAST) state_d = NORM;
        else                 state_d = MUL;
      end
      NORM:    state_d = DONE;
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
        else               state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; handshake flags track the state being entered.
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    count_d     = count_q;
    acc_d       = acc_q;
    out_d       = out_q;
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          a_d     = bus.a;
          b_d     = bus.b;
          count_d = '0;
          acc_d   = '0;
          if (cls_s != CLS_NORMAL) out_d = encode_special(sign_in_s, cls_s);
          else                     out_d = out_q;
        end else begin
          a_d = a_q;
        end
      end
      MUL: begin
        if (sb_s[count_q]) acc_d = acc_q + ({{M{1'b0}}, sa_s} << count_q);
        else               acc_d = acc_q;
        count_d = count_q + CW'(1);
      end
      NORM: begin
        if (e_s >= EMAX)       out_d = encode_special(sign_s, CLS_INF);
        else if (e_s <= EZERO) out_d = encode_special(sign_s, CLS_ZERO);
        else                   out_d = {sign_s, e_s[EXP_LEN-1:0], mant_s};
      end
      DONE:    out_d = out_q;
      default: out_d = out_q;
    endcase
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
endmodule

// File: tb/tb_fmul_seq.sv
// Directed-vector bench for fmul_seq (N=32): results, latency, handshake hold and mid-op reset.
module tb_fmul_seq;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  fmul_seq_if #(.N(32)) bus ();

  fmul_seq #(.N(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Present operands at a falling edge; the following rising edge is the accept edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic rdy);
    @(negedge clk);
    bus.a         = a;
    bus.b         = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = rdy;
    check_eq("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) break;
      if (lat > 200) begin
        lat = -1;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    start_op(a, b, 1'b1);
    wait_valid(lat);
    check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "_out"}, 64'(bus.out), 64'(exp));
    @(negedge clk);
    check_eq({tag, "_valid_cleared"}, 64'(bus.out_valid), 64'd0);
    check_eq({tag, "_ready_again"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    int lat;
    logic [31:0] held;
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = 32'h0000_0000;
    bus.b         = 32'h0000_0000;
    bus.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    check_eq("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("reset_out", 64'(bus.out), 64'd0);
    rst_n = 1'b1;

    run_op("mul_1p5x2",   32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 26);
    run_op("mul_3x3",     32'h4040_0000, 32'h4040_0000, 32'h4110_0000, 26);
    run_op("sign_neg",    32'hC000_0000, 32'h3F00_0000, 32'hBF80_0000, 26);
    run_op("inf_x_zero",  32'h7F80_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1);
    run_op("neg_inf",     32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, 1);
    run_op("denorm",      32'h0040_0000, 32'h4000_0000, 32'h0000_0000, 1);
    run_op("nan_in",      32'h7FC0_0000, 32'h3F80_0000, 32'h7FFF_FFFF, 1);
    run_op("overflow",    32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 26);
    run_op("underflow",   32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 26);

    // Consumer stalls for 10 cycles; new operands offered meanwhile must be ignored.
    start_op(32'h4040_0000, 32'h4040_0000, 1'b0);
    wait_valid(lat);
    check_eq("hold_latency", 64'(lat), 64'd26);
    held = bus.out;
    check_eq("hold_out", 64'(held), 64'h4110_0000);
    bus.a        = 32'h7F80_0000;
    bus.b        = 32'h0000_0000;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("hold_out_stable", 64'(bus.out), 64'(held));
      check_eq("hold_valid_high", 64'(bus.out_valid), 64'd1);
      check_eq("hold_in_ready_low", 64'(bus.in_ready), 64'd0);
      bus.in_valid = ~bus.in_valid;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_eq("hold_release_valid", 64'(bus.out_valid), 64'd0);
    check_eq("hold_release_ready", 64'(bus.in_ready), 64'd1);
    check_eq("hold_out_kept", 64'(bus.out), 64'h4110_0000);
    run_op("after_hold", 32'hC000_0000, 32'h3F00_0000, 32'hBF80_0000, 26);

    // Asynchronous reset in the middle of the multiply loop.
    start_op(32'h3FC0_0000, 32'h4000_0000, 1'b1);
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("midrst_out", 64'(bus.out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        check_eq("midrst_no_pulse", 64'(bus.out_valid), 64'd0);
        break;
      end
    end
    run_op("post_reset", 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 26);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
